// File: rtl/ps2_scancode_ctrl.sv
// ps2_scancode_ctrl: Set-2 scan-code prefix decoder with make/break event FIFO and key tracking.
// Optional feature: define PS2_REPEAT_FILTER_EN to suppress typematic repeats of the held key.
module ps2_scancode_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int AW = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_err,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       key_down,
    output logic [8:0] cur_code,
    output logic [7:0] press_cnt,
    output logic [7:0] err_cnt,
    output logic       overflow
);
    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);
    state_t state;
    logic ok, is_pre, in_ext, in_brk, emit, push, err_hit, pop, full, accept;
    logic [9:0] mem [FIFO_DEPTH];
    logic [9:0] head;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0] count;

    // Classify the incoming byte against the pending prefixes and derive FIFO handshakes
    always_comb begin
        ok = rx_valid & ~rx_err;
        is_pre = rx_data == 8'hE0 || rx_data == 8'hF0;
        in_ext = state == EXT || state == EXT_BRK;
        in_brk = state == BRK || state == EXT_BRK;
        emit = ok & ~is_pre;
        err_hit = (rx_valid & rx_err) | (ok & is_pre & in_brk);
`ifdef PS2_REPEAT_FILTER_EN
        push = emit & ~(~in_brk & key_down & cur_code == {in_ext, rx_data});
`else
        push = emit;
`endif
        ev_valid = count != '0;
        pop = ev_valid & ev_ready;
        full = count == FULL_COUNT;
        accept = push & (~full | pop);
        head = mem[rd_ptr];
        ev_code = ev_valid ? head[7:0] : 8'h00;
        ev_break = ev_valid & head[8];
        ev_ext = ev_valid & head[9];
    end

    // Prefix state machine, held-key tracking and event/error counters
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            key_down <= 1'b0;
            cur_code <= '0;
            press_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if (rx_valid)
                state <= rx_err ? IDLE :
                         (state == IDLE && rx_data == 8'hE0) ? EXT :
                         (state == IDLE && rx_data == 8'hF0) ? BRK :
                         (state == EXT && rx_data == 8'hF0) ? EXT_BRK :
                         (state == EXT && rx_data == 8'hE0) ? EXT : IDLE;
            if (err_hit && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
            if (push && !in_brk) begin
                key_down <= 1'b1;
                cur_code <= {in_ext, rx_data};
                press_cnt <= press_cnt + 8'd1;
            end else if (push && key_down && cur_code == {in_ext, rx_data}) begin
                key_down <= 1'b0;
            end
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(accept) - (AW+1)'(pop);
            if (push && full && !pop)
                overflow <= 1'b1;
        end
    end

    // Event storage; contents are masked by the empty flag so no reset is needed
    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= {in_ext, in_brk, rx_data};
    end
endmodule

// File: doc/ps2_scancode_ctrl.md
Name: ps2_scancode_ctrl

Overview:
Sequencing controller between the PS/2 byte receiver and the rest of the keyboard path. Consumes validated scan-code bytes and runs the Set-2 prefix state machine (E0 extended, F0 break). Emits one make/break event per key transition into a small event FIFO with a valid/ready interface. Tracks the currently held key and a press counter for display logic.

Parameters:
FIFO_DEPTH, 4, event FIFO entries; power of two, at least 2
AW, 2, FIFO pointer width; must equal log2(FIFO_DEPTH)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
rx_data  in  8  received scan-code byte
rx_err  in  1  qualifies rx_valid: start, stop or parity failure on this byte
ev_valid  out  1  event FIFO not empty
ev_ready  in  1  consumer accepts the head event when ev_valid is high
ev_code  out  8  head event scan code (prefixes stripped)
ev_ext  out  1  head event carried the E0 prefix
ev_break  out  1  head event is a release (F0 seen)
key_down  out  1  a key is currently held
cur_code  out  9  held key as {ext, code}
press_cnt  out  8  count of decoded make events, wraps
err_cnt  out  8  dropped or errored bytes, saturates at 8'hFF
overflow  out  1  sticky: an event was lost because the FIFO was full

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, FIFO empty, ev_valid=0, ev_code=0, ev_ext=0, ev_break=0, key_down=0, cur_code=0, press_cnt=0, err_cnt=0, overflow=0. Reset mid-sequence discards any partial prefix.
- Only cycles with rx_valid=1 advance the FSM. With rx_valid=0 all state holds.
- rx_valid & rx_err: byte dropped, FSM->IDLE, err_cnt+1 (saturating). No event.
- FSM, byte b, valid with no error:
  - IDLE: b=E0 -> EXT. b=F0 -> BRK. Otherwise emit make{ext=0,b}, stay IDLE.
  - EXT: b=F0 -> EXT_BRK. b=E0 -> stay EXT. Otherwise emit make{ext=1,b}, go IDLE.
  - BRK: b=E0 or F0 -> protocol error: err_cnt+1, go IDLE. Otherwise emit break{ext=0,b}, go IDLE.
  - EXT_BRK: b=E0 or F0 -> protocol error, go IDLE. Otherwise emit break{ext=1,b}, go IDLE.
- Emit at cycle N (rx_valid cycle). Entry is written at the clock edge ending N, so ev_valid=1 and head fields are visible in cycle N+1.
- FIFO: entry is {ext, brk, code}. Head fields are driven combinationally from the read pointer. A pop occurs on an edge where ev_valid & ev_ready.
  - Push when full and no pop in the same cycle: event dropped, overflow set. overflow clears only on reset.
  - Push when full with a pop in the same cycle: push accepted, occupancy unchanged.
  - Push and pop on a one-entry FIFO: occupancy stays 1, the new event becomes head.
  - ev_ready while empty: no effect.
  - Pointers are AW bits wide and wrap naturally. Full/empty use an occupancy counter of AW+1 bits.
- Key tracking, updated at the emit edge whether or not the FIFO accepted the event:
  - make: key_down=1, cur_code={ext,code}, press_cnt+1 (8'hFF wraps to 0).
  - break matching cur_code while key_down: key_down=0. cur_code keeps its value.
  - break not matching: no change.
- ev_* outputs are 0 when the FIFO is empty.

Optional Feature:
Macro PS2_REPEAT_FILTER_EN.
- Defined: a make event whose {ext,code} equals cur_code while key_down=1 (typematic repeat) is suppressed. No FIFO push, press_cnt unchanged, FSM still returns to IDLE.
- Undefined: every make is emitted and counted.

Test Plan:
- Bytes 1C, F0, 1C -> events make{0,1C} then break{0,1C}. press_cnt=1. key_down goes 1 then 0. Each ev_valid rises the cycle after its final byte.
- Bytes E0 75, E0 F0 75 -> make{ext=1,75}, break{ext=1,75}. cur_code=9'h175. key_down=0 at end.
- ev_ready=0, send 5 make codes 15,1D,24,2D,2C with FIFO_DEPTH=4 -> first 4 queued in order, 2C lost, overflow=1. Then ev_ready=1 drains 15,1D,24,2D and ev_valid drops.
- F0 then E0 -> err_cnt=1, FSM IDLE. Next byte 1C gives make{0,1C}. Separately, rx_err on the byte after E0 -> err_cnt+1 and the following 1C is a non-extended make.
- Bytes 1C,1C,1C then F0 1C: with PS2_REPEAT_FILTER_EN, 2 events and press_cnt=1. Without it, 4 events and press_cnt=3.
- Assert resetn low between E0 and F0 -> all outputs 0. After release, byte 1C gives make{ext=0,1C}.
